// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, ID register
// layout and the default source count.
package irq_ctrl_pkg;

  localparam int IRQ_N_SRC = 5;
  localparam int IRQ_ID_W  = 3;

  localparam logic [3:0] IRQ_PENDING_OFS = 4'h0;
  localparam logic [3:0] IRQ_ENABLE_OFS  = 4'h4;
  localparam logic [3:0] IRQ_MODE_OFS    = 4'h8;
  localparam logic [3:0] IRQ_ID_OFS      = 4'hC;

  localparam int IRQ_ID_VALID_BIT = 31;

  typedef logic [IRQ_ID_W-1:0] irq_id_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw request line, plus a history flop so that a
// rising edge can be seen one cycle after the line reaches the synchronised stage.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic level,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= src;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~s3_reg;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge/level capture into PENDING, ENABLE
// masking, lowest-index-first priority encoding and a small register file.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC        = IRQ_N_SRC,
  parameter logic [N_SRC-1:0] ENABLE_RESET = 5'h1F,
  parameter logic [N_SRC-1:0] MODE_RESET   = 5'h1F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_ack,
  input  logic [2:0]       i_ack_id,
  input  logic             i_bus_we,
  input  logic             i_bus_re,
  input  logic [3:0]       i_bus_addr,
  input  logic [31:0]      i_bus_wdata,
  output logic [31:0]      o_bus_rdata,
  output logic [N_SRC-1:0] o_interruption,
  output logic             o_irq_valid,
  output logic [2:0]       o_irq_id
);

  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] enable_reg;
  logic [N_SRC-1:0] mode_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      rdata_next;

  logic [N_SRC-1:0] level;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] mode_chg;

  logic [3:0] word_addr;
  logic       wr_pending;
  logic       wr_enable;
  logic       wr_mode;
  irq_id_t    irq_id;
  logic       unused_bits;

  assign word_addr  = {i_bus_addr[3:2], 2'b00};
  assign wr_pending = i_bus_we && (word_addr == IRQ_PENDING_OFS);
  assign wr_enable  = i_bus_we && (word_addr == IRQ_ENABLE_OFS);
  assign wr_mode    = i_bus_we && (word_addr == IRQ_MODE_OFS);

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .src   (i_irq_src[gi]),
        .level (level[gi]),
        .rise  (rise[gi])
      );

      // An ack id at or above N_SRC never matches any gi, so it is ignored.
      assign clr[gi] = (i_ack && (i_ack_id == IRQ_ID_W'(gi)))
                     | (wr_pending && i_bus_wdata[gi]);
      assign mode_chg[gi] = wr_mode && (i_bus_wdata[gi] != mode_reg[gi]);

      // Priority: mode switch flush, then level tracking, then set-over-clear.
      assign pending_next[gi] = mode_chg[gi]  ? 1'b0 :
                                !mode_reg[gi] ? level[gi] :
                                rise[gi]      ? 1'b1 :
                                clr[gi]       ? 1'b0 : pending_reg[gi];
    end
  endgenerate

  assign o_interruption = pending_reg & enable_reg;
  assign o_irq_valid    = |o_interruption;

  always_comb begin
    irq_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (o_interruption[i]) irq_id = IRQ_ID_W'(i);
    end
  end
  assign o_irq_id = irq_id;

  always_comb begin
    rdata_next = '0;
    case (word_addr)
      IRQ_PENDING_OFS: rdata_next[N_SRC-1:0] = pending_reg;
      IRQ_ENABLE_OFS:  rdata_next[N_SRC-1:0] = enable_reg;
      IRQ_MODE_OFS:    rdata_next[N_SRC-1:0] = mode_reg;
      IRQ_ID_OFS: begin
        rdata_next[IRQ_ID_VALID_BIT] = o_irq_valid;
        rdata_next[IRQ_ID_W-1:0]     = irq_id;
      end
      default:         rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= '0;
      enable_reg  <= ENABLE_RESET;
      mode_reg    <= MODE_RESET;
      rdata_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      if (wr_enable) enable_reg <= i_bus_wdata[N_SRC-1:0];
      if (wr_mode)   mode_reg   <= i_bus_wdata[N_SRC-1:0];
      if (i_bus_re)  rdata_reg  <= rdata_next;
    end
  end

  assign o_bus_rdata = rdata_reg;
  assign unused_bits = ^{i_bus_addr[1:0], i_bus_wdata[31:N_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues hand-computed expectations,
// a monitor pops and compares on each read return or interrupt snapshot.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  src;
  logic        ack;
  logic [2:0]  ack_id;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [4:0]  interruption;
  logic        irq_valid;
  logic [2:0]  irq_id;

  typedef struct {
    bit          is_rd;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rd_d = 1'b0;
  bit   snap = 1'b0;
  bit   stim_done = 1'b0;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .i_irq_src      (src),
    .i_ack          (ack),
    .i_ack_id       (ack_id),
    .i_bus_we       (we),
    .i_bus_re       (re),
    .i_bus_addr     (addr),
    .i_bus_wdata    (wdata),
    .o_bus_rdata    (rdata),
    .o_interruption (interruption),
    .o_irq_valid    (irq_valid),
    .o_irq_id       (irq_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_d <= re;

  task automatic check(input bit is_rd, input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output: got %h, nothing expected", act);
    end else begin
      e = q.pop_front();
      if (e.is_rd != is_rd || act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  initial begin : monitor
    int idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rd_d) check(1'b1, rdata);
      if (snap) check(1'b0, {irq_valid, 23'b0, irq_id, interruption});
      if (stim_done) begin
        if (q.size() == 0) begin
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $finish;
        end
        idle++;
        if (idle > 20) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drain_timeout: got %0d left in queue, required 0", q.size());
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $finish;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    re   = 1'b1;
    addr = a;
    q.push_back('{is_rd: 1'b1, name: nm, exp: e});
    step(1);
    re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    we = 1'b0;
  endtask

  task automatic chk_irq(input string nm, input logic [4:0] i5, input logic [2:0] id, input logic v);
    q.push_back('{is_rd: 1'b0, name: nm, exp: {v, 23'b0, id, i5}});
    snap = 1'b1;
    @(negedge clk);
    #1 snap = 1'b0;
  endtask

  task automatic ack_pulse(input logic [2:0] id);
    ack    = 1'b1;
    ack_id = id;
    step(1);
    ack = 1'b0;
  endtask

  // Source high for one sampling edge; pending is set once this returns.
  task automatic pulse(input logic [4:0] m);
    src = m;
    step(1);
    src = '0;
    step(2);
  endtask

  initial begin : stimulus
    reset = 1'b0; src = '0; ack = 1'b0; ack_id = '0;
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    step(2);
    chk_irq("in_reset_irq", 5'b0, 3'd0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    step(1);
    rd(4'h4, 32'h1F, "rst_enable");
    rd(4'h8, 32'h1F, "rst_mode");
    rd(4'h0, 32'h0,  "rst_pending");
    rd(4'hC, 32'h0,  "rst_id");
    chk_irq("rst_irq", 5'b0, 3'd0, 1'b0);

    // Single-cycle pulse on source 2: visible only from edge k+2.
    src = 5'b00100;
    step(1);
    src = '0;
    chk_irq("edge_k", 5'b0, 3'd0, 1'b0);
    step(1);
    chk_irq("edge_k1", 5'b0, 3'd0, 1'b0);
    step(1);
    chk_irq("edge_k2", 5'b00100, 3'd2, 1'b1);
    step(3);
    chk_irq("edge_hold", 5'b00100, 3'd2, 1'b1);
    ack_pulse(3'd2);
    chk_irq("ack_clear", 5'b0, 3'd0, 1'b0);
    rd(4'h0, 32'h0, "ack_pending");

    // Two sources, priority and W1C.
    pulse(5'b01010);
    chk_irq("two_src", 5'b01010, 3'd1, 1'b1);
    wr(4'h0, 32'h2);
    chk_irq("w1c_bit1", 5'b01000, 3'd3, 1'b1);
    rd(4'hC, 32'h8000_0003, "id_reg");
    rd(4'h0, 32'h8, "pending_after_w1c");
    wr(4'h0, 32'h8);
    chk_irq("w1c_all", 5'b0, 3'd0, 1'b0);

    // Masked capture, unmask, ignored writes, byte-offset bits.
    wr(4'h4, 32'h0);
    pulse(5'b00001);
    chk_irq("masked", 5'b0, 3'd0, 1'b0);
    rd(4'h0, 32'h1, "masked_pending");
    rd(4'hC, 32'h0, "masked_id");
    wr(4'h4, 32'h1);
    chk_irq("unmasked", 5'b00001, 3'd0, 1'b1);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h4, 32'h1, "enable_after_id_wr");
    wr(4'h7, 32'hFFFF_FFFF);
    rd(4'h6, 32'h1F, "enable_lowbits");
    chk_irq("after_id_wr", 5'b00001, 3'd0, 1'b1);
    ack = 1'b1; ack_id = 3'd0;
    we = 1'b1; addr = 4'h0; wdata = 32'h1;
    step(1);
    ack = 1'b0; we = 1'b0;
    chk_irq("ack_w1c", 5'b0, 3'd0, 1'b0);

    // Rise on source 4 coincident with its ack: set wins.
    pulse(5'b10000);
    chk_irq("src4", 5'b10000, 3'd4, 1'b1);
    src = 5'b10000;
    step(1);
    src = '0;
    step(1);
    ack = 1'b1; ack_id = 3'd4;
    step(1);
    ack = 1'b0;
    chk_irq("set_wins", 5'b10000, 3'd4, 1'b1);
    rd(4'h0, 32'h10, "set_wins_pending");
    ack_pulse(3'd5);
    chk_irq("ack_id5", 5'b10000, 3'd4, 1'b1);
    ack_pulse(3'd4);
    chk_irq("ack4", 5'b0, 3'd0, 1'b0);

    // Level mode tracks the synchronised source; ack/W1C have no effect.
    wr(4'h8, 32'h0);
    rd(4'h8, 32'h0, "mode_level");
    src = 5'b00001;
    step(3);
    chk_irq("level_on", 5'b00001, 3'd0, 1'b1);
    ack_pulse(3'd0);
    chk_irq("level_ack", 5'b00001, 3'd0, 1'b1);
    wr(4'h0, 32'h1);
    chk_irq("level_w1c", 5'b00001, 3'd0, 1'b1);
    src = '0;
    step(2);
    chk_irq("level_hold", 5'b00001, 3'd0, 1'b1);
    step(1);
    chk_irq("level_off", 5'b0, 3'd0, 1'b0);
    src = 5'b00001;
    step(3);
    chk_irq("level_on2", 5'b00001, 3'd0, 1'b1);
    wr(4'h8, 32'h1F);
    chk_irq("mode_wr_clear", 5'b0, 3'd0, 1'b0);
    step(2);
    chk_irq("edge_no_rise", 5'b0, 3'd0, 1'b0);
    rd(4'h8, 32'h1F, "mode_edge");
    src = '0;
    step(3);

    // Read and write to the same register: read returns the old value.
    re = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'h15;
    q.push_back('{is_rd: 1'b1, name: "rw_same_cycle", exp: 32'h1F});
    step(1);
    re = 1'b0; we = 1'b0;
    rd(4'h4, 32'h15, "enable_new");

    // Reset mid-pending, with source activity held off by reset.
    pulse(5'b00110);
    chk_irq("pre_reset", 5'b00100, 3'd2, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    chk_irq("reset_async", 5'b0, 3'd0, 1'b0);
    src = 5'b00001;
    step(2);
    src = '0;
    step(3);
    reset = 1'b1;
    step(4);
    chk_irq("post_reset", 5'b0, 3'd0, 1'b0);
    rd(4'h4, 32'h1F, "post_reset_enable");
    rd(4'h0, 32'h0,  "post_reset_pending");
    rd(4'h8, 32'h1F, "post_reset_mode");
    stim_done = 1'b1;
  end

endmodule
